// File: rtl/ones_pattern_generator_pkg.sv
// Shared definitions for the thermometer-code (ones pattern) generator.
// Vector width is derived from the count width so that any legal count fits the word.
package ones_pattern_generator_pkg;

  localparam int DEFAULT_N    = 6;
  localparam int DEFAULT_STEP = 8;

  function automatic int vec_width(input int n);
    return (2 ** (n + 1)) - 1;
  endfunction

  // Encoding 2'd3 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ones_pattern_generator_step_mask.sv
// Combinational mask of s right-justified ones (2^s - 1), STEP bits wide.
module ones_step_mask #(
  parameter int STEP = 8,
  parameter int SW   = 4
) (
  input  logic [SW-1:0]   s,
  output logic [STEP-1:0] mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < STEP; i++) begin
      mask[i] = (i < int'(s));
    end
  end

endmodule

// File: rtl/ones_pattern_generator.sv
// Builds a W-bit word holding exactly k right-justified ones, inserting up to STEP ones per cycle.
// Start/done handshake; ready/busy/done are decoded from state only.
module ones_pattern_generator
  import ones_pattern_generator_pkg::*;
#(
  parameter  int N    = DEFAULT_N,
  parameter  int STEP = DEFAULT_STEP,
  localparam int W    = vec_width(N),
  localparam int SW   = $clog2(STEP + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N:0]   count,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] vec
);

  state_t          state;
  state_t          state_next;
  logic [N:0]      remaining;
  logic [N:0]      rem_next;
  logic [SW-1:0]   s;
  logic [STEP-1:0] mask;

  // Ones inserted this cycle: min(STEP, remaining)
  always_comb begin
    s = SW'(remaining);
    if (remaining > (N + 1)'(STEP)) begin
      s = SW'(STEP);
    end
  end

  assign rem_next = remaining - (N + 1)'(s);

  ones_step_mask #(
    .STEP (STEP),
    .SW   (SW)
  ) u_step_mask (
    .s    (s),
    .mask (mask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready      = 1'b1;
        state_next = start ? FILL : IDLE;
      end
      FILL: begin
        busy       = 1'b1;
        state_next = (rem_next == '0) ? DONE : FILL;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
      vec       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= count;
            vec       <= '0;
          end
        end
        FILL: begin
          remaining <= rem_next;
          vec       <= (vec << s) | W'(mask);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ones_pattern_generator.sv
// Self-checking bench for ones_pattern_generator: vector table, corner sequences and random jobs.
module tb_ones_pattern_generator;
  import ones_pattern_generator_pkg::*;

  localparam int N    = 6;
  localparam int STEP = 8;
  localparam int W    = vec_width(N);

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N:0]   count;
  logic         ready, busy, done;
  logic [W-1:0] vec;

  int errors = 0;
  int checks = 0;

  ones_pattern_generator #(.N(N), .STEP(STEP)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .count (count),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .vec   (vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    int k;
    int fills;
    int ones;
  } tv_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] model_vec(input int ones);
    logic [127:0] one;
    one = 128'd1;
    return (one << ones) - 128'd1;
  endfunction

  function automatic int model_fills(input int k);
    return (k == 0) ? 1 : (k + STEP - 1) / STEP;
  endfunction

  function automatic int ones_after(input int k, input int i);
    return (i * STEP < k) ? i * STEP : k;
  endfunction

  // Wait for ready, issue one job, follow it to done and one cycle beyond.
  task automatic run_job(input int k, input int exp_fills, input int exp_ones, input bit poke);
    int n;
    bit got;
    @(negedge clk);
    n = 0;
    while (!ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", ready, 1'b1);
    start = 1'b1;
    count = (N + 1)'(k);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", {ready, busy, done}, 3'b010);
    chk("vec_cleared", vec, '0);
    got = 1'b0;
    for (int i = 1; i <= exp_fills + 2 && !got; i++) begin
      @(posedge clk); #1;
      if (poke) start = 1'b0;
      if (done) begin
        got = 1'b1;
        chk("fill_cycles", i, exp_fills);
        chk("vec_final", vec, model_vec(k));
        chk("popcount", $countones(vec), exp_ones);
      end else begin
        chk("vec_partial", vec, model_vec(ones_after(k, i)));
        chk("busy_fill", busy, 1'b1);
        if (poke && i == 1) begin
          start = 1'b1;
          count = 7'd5;
        end
      end
    end
    if (!got) chk("done_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("post_done_state", {ready, busy, done}, 3'b100);
    chk("vec_held", vec, model_vec(k));
    if (poke) begin
      @(posedge clk); #1;
      chk("poke_not_queued", {ready, busy}, 2'b10);
      chk("vec_still_held", vec, model_vec(k));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv_t tbl[10];
    int bb[3];
    int n;
    bit got;

    tbl = '{'{0, 1, 0}, '{1, 1, 1}, '{7, 1, 7}, '{8, 1, 8}, '{9, 2, 9},
            '{16, 2, 16}, '{17, 3, 17}, '{64, 8, 64}, '{100, 13, 100}, '{127, 16, 127}};
    bb = '{1, 64, 127};

    rst = 1'b1;
    start = 1'b0;
    count = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {ready, busy, done}, 3'b100);
    chk("reset_vec", vec, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 10; t++) begin
      run_job(tbl[t].k, tbl[t].fills, tbl[t].ones, 1'b0);
    end

    // k=9 with a start pulse during FILL that must be dropped
    run_job(9, 2, 9, 1'b1);

    // Async reset while idle with a nonzero vec
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("async_rst_idle_vec", vec, '0);
    chk("async_rst_idle_state", {ready, busy, done}, 3'b100);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the 5th FILL cycle of k=100
    @(negedge clk);
    start = 1'b1;
    count = 7'd100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midfill_busy", busy, 1'b1);
    chk("midfill_vec", vec, model_vec(32));
    #1;
    rst = 1'b1;
    #1;
    chk("midfill_rst_vec", vec, '0);
    chk("midfill_rst_state", {ready, busy, done}, 3'b100);
    @(negedge clk);
    rst = 1'b0;
    run_job(3, 1, 3, 1'b0);

    // Back-to-back with start held high
    start = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      count = (N + 1)'(bb[j]);
      n = 0;
      while (!ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_ready_wait", ready, 1'b1);
      @(posedge clk); #1;
      chk("b2b_accept", busy, 1'b1);
      got = 1'b0;
      for (int i = 1; i <= model_fills(bb[j]) + 2 && !got; i++) begin
        @(posedge clk); #1;
        if (done) begin
          got = 1'b1;
          chk("b2b_fill_cycles", i, model_fills(bb[j]));
          chk("b2b_vec", vec, model_vec(bb[j]));
          chk("b2b_popcount", $countones(vec), bb[j]);
        end
      end
      if (!got) chk("b2b_done_timeout", 1'b0, 1'b1);
    end
    @(posedge clk); #1;
    chk("b2b_done_single", {ready, done}, 2'b10);
    start = 1'b0;

    // Random jobs with random idle gaps
    for (int r = 0; r < 20; r++) begin
      int k;
      k = int'($urandom_range(0, W));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_job(k, model_fills(k), k, ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
